fp_div_seq: RTL and testbench
=============================

Name: fp_div_seq

Overview:
- Sequential IEEE-754 single-precision divider, fp_Z = fp_X / fp_Y.
- Complements the combinational multiplier in the FPU datapath with the inverse operation.
- Uses the same conventions as the multiplier: subnormals flushed to zero, sign = X^Y, a 27-bit normalized fraction (24 mantissa + guard + 2 round/sticky), and the same r_mode encoding.
- Radix-2 restoring division, one quotient bit per cycle, with a start/done handshake toward the ALU sequencer.

Parameters:
- QBITS, 28, quotient bits produced: 1 integer bit, 23 fraction bits, 4 extra bits for normalization/guard/round.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  operation request; sampled only in IDLE
- fp_X  in  32  dividend
- fp_Y  in  32  divisor
- r_mode  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, 101-111 treated as RNE
- fp_Z  out  32  quotient; held until the next completion
- ovrf  out  1  overflow/divide-by-zero flag; held with fp_Z
- udrf  out  1  underflow flag; held with fp_Z
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, any state): state=IDLE; fp_Z=0, ovrf=0, udrf=0, busy=0, done=0. An operation in flight is aborted with no done pulse.
- States: IDLE, SPECIAL, DIV, ROUND.
- IDLE + start at edge t0:
  - latch fp_X, fp_Y, r_mode; busy=1.
  - classify; a special case goes to SPECIAL, otherwise to DIV with counter=0.
- start while busy is ignored; the latched operands do not change.
- start is accepted in the cycle in which done is high, because the block is already back in IDLE.
- Operand classification:
  - exponent field 0 (zero or subnormal) counts as zero;
  - exponent 255 with frac=0 is Inf;
  - exponent 255 with frac!=0 is NaN.
- Special-case priority (first match wins; result written at edge t1, latency 1):
  - any NaN, 0/0, or Inf/Inf -> 0x7FC00000;
  - finite/0 -> {s,0x7F800000}, ovrf=1;
  - Inf/finite -> {s,Inf};
  - 0/x or finite/Inf -> {s,31'b0}.
  - Here s = fp_X[31]^fp_Y[31].
- DIV datapath:
  - mx={1,frc_X}, my={1,frc_Y}; remainder R (25 bits) initialised to mx.
  - Each cycle: if R>=my then q_bit=1 and R=R-my, else q_bit=0; then R=R<<1; q={q[QBITS-2:0],q_bit}.
  - Exactly QBITS cycles (edges t1..t28), then go to ROUND.
- Normalization (ROUND state):
  - sticky = |R.
  - If q[27]=1: norm = {q[27:2], |{q[1:0],sticky}} and E = eX-eY+127.
  - Otherwise: norm = {q[26:1], |{q[0],sticky}} and E = eX-eY+126.
  - norm[26] is always 1. E is computed signed, 10 bits.
- Rounding on norm (mantissa = norm[26:3], g = norm[2], st = |norm[1:0]):
  - RNE: increment if g & (st | norm[3]).
  - RTZ: never increment.
  - RDN: increment if sign & (g|st).
  - RUP: increment if !sign & (g|st).
  - RMM: increment if g.
- Rounding carry: if the mantissa increment carries out, mantissa becomes 1.000 and E=E+1.
- Range checks after rounding:
  - E>=255 -> {s,Inf}, ovrf=1.
  - E<=0 -> {s,31'b0}, udrf=1 (no subnormal output).
  - Otherwise fp_Z = {s, E[7:0], mantissa[22:0]}.
- Completion:
  - Result and flags are registered at edge t29 (normal path) or t1 (special path).
  - At the same edge: done=1 for one cycle, busy=0, state returns to IDLE.
  - Flags are cleared at each completion unless set by that completion.
- Latency from start: 29 cycles normal, 1 cycle special.

Test Plan:
- 0x40C00000/0x40000000, RNE -> fp_Z=0x40400000, ovrf=udrf=0, done 29 cycles after start, busy high for exactly those 29 cycles.
- 0x3F800000/0x40400000 with each mode:
  - RNE -> 0x3EAAAAAB
  - RTZ -> 0x3EAAAAAA
  - RDN -> 0x3EAAAAAA
  - RUP -> 0x3EAAAAAB
  - RMM -> 0x3EAAAAAB
- 0xBF800000/0x40400000: RDN -> 0xBEAAAAAB; RUP -> 0xBEAAAAAA.
- Special cases, each with done after 1 cycle:
  - 0x3F800000/0x00000000 -> 0x7F800000, ovrf=1
  - 0x00000000/0x80000000 -> 0x7FC00000
  - 0x80000000/0x3F800000 -> 0x80000000
  - 0x7F800000/0x7F800000 -> 0x7FC00000
  - 0x00400000 (subnormal)/0x3F800000 -> 0x00000000
- Range limits:
  - 0x7F000000/0x00800000 -> 0x7F800000, ovrf=1.
  - 0x00800000/0x40000000 -> 0x00000000, udrf=1.
  - A subsequent 0x40C00000/0x40000000 -> 0x40400000 with both flags cleared.
- Handshake and reset:
  - start held high throughout an operation -> latched operands unchanged mid-operation; a new operation starts only in the done cycle.
  - rst pulsed 10 cycles into DIV -> busy=0, fp_Z=0, no done pulse; the next start completes normally in 29 cycles.

Source files
------------

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider (radix-2 restoring, one quotient bit per cycle).
// Subnormals flush to zero; result and flags are held until the next completion.
module fp_div_seq #(
  parameter int unsigned QBITS = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CntW = $clog2(QBITS);

  typedef enum logic [1:0] {StIdle, StSpecial, StDiv, StRound} state_e;

  function automatic logic f_is_zero(input logic [31:0] v);
    return v[30:23] == 8'd0;
  endfunction

  function automatic logic f_is_inf(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
  endfunction

  function automatic logic f_is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  state_e            r_state, w_state_nxt;
  logic [31:0]       r_x, w_x_nxt;
  logic [31:0]       r_y, w_y_nxt;
  logic [2:0]        r_rmode, w_rmode_nxt;
  logic [24:0]       r_rem, w_rem_nxt;
  logic [QBITS-1:0]  r_quo, w_quo_nxt;
  logic [CntW-1:0]   r_cnt, w_cnt_nxt;
  logic [31:0]       r_z, w_z_nxt;
  logic              r_ovrf, w_ovrf_nxt;
  logic              r_udrf, w_udrf_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  // Classification of the incoming operands decides the branch taken at acceptance.
  logic w_in_special;
  assign w_in_special = f_is_zero(fp_X) | f_is_inf(fp_X) | f_is_nan(fp_X) |
                        f_is_zero(fp_Y) | f_is_inf(fp_Y) | f_is_nan(fp_Y);

  logic w_sign;
  assign w_sign = r_x[31] ^ r_y[31];

  // Special-case result from the latched operands; first match wins.
  logic [31:0] w_sp_z;
  logic        w_sp_ovrf;
  always_comb begin
    w_sp_z    = {w_sign, 31'd0};
    w_sp_ovrf = 1'b0;
    if (f_is_nan(r_x) || f_is_nan(r_y) || (f_is_zero(r_x) && f_is_zero(r_y)) ||
        (f_is_inf(r_x) && f_is_inf(r_y))) begin
      w_sp_z = 32'h7FC0_0000;
    end else if (f_is_zero(r_y) && !f_is_inf(r_x)) begin
      w_sp_z    = {w_sign, 31'h7F80_0000};
      w_sp_ovrf = 1'b1;
    end else if (f_is_inf(r_x)) begin
      w_sp_z = {w_sign, 31'h7F80_0000};
    end
  end

  // One restoring-division step.
  logic [24:0] w_my;
  logic        w_ge;
  logic [24:0] w_rem_sub;
  assign w_my      = {2'b01, r_y[22:0]};
  assign w_ge      = r_rem >= w_my;
  assign w_rem_sub = w_ge ? (r_rem - w_my) : r_rem;

  // Normalization: w_norm holds the 23 fraction bits, guard and a 2-bit round/sticky field.
  logic              w_sticky;
  logic [25:0]       w_norm;
  logic signed [9:0] w_exp_base, w_exp_n, w_exp_f;
  logic              w_g, w_st, w_inc;
  logic [23:0]       w_frac_sum;
  logic [31:0]       w_rnd_z;
  logic              w_rnd_ovrf, w_rnd_udrf;

  assign w_sticky   = |r_rem;
  assign w_exp_base = $signed({2'b00, r_x[30:23]}) - $signed({2'b00, r_y[30:23]}) + 10'sd127;

  always_comb begin
    if (r_quo[QBITS-1]) begin
      w_norm  = {r_quo[QBITS-2:2], |{r_quo[1:0], w_sticky}};
      w_exp_n = w_exp_base;
    end else begin
      w_norm  = {r_quo[QBITS-3:1], |{r_quo[0], w_sticky}};
      w_exp_n = w_exp_base - 10'sd1;
    end
  end

  assign w_g  = w_norm[2];
  assign w_st = |w_norm[1:0];

  always_comb begin
    unique case (r_rmode)
      3'b001:  w_inc = 1'b0;
      3'b010:  w_inc = w_sign & (w_g | w_st);
      3'b011:  w_inc = !w_sign & (w_g | w_st);
      3'b100:  w_inc = w_g;
      default: w_inc = w_g & (w_st | w_norm[3]);
    endcase
  end

  // The hidden bit is always 1, so a carry out of the fraction is the mantissa carry;
  // the wrapped fraction is then already zero.
  assign w_frac_sum = {1'b0, w_norm[25:3]} + {23'd0, w_inc};
  assign w_exp_f    = w_exp_n + $signed({9'd0, w_frac_sum[23]});

  always_comb begin
    w_rnd_z    = {w_sign, w_exp_f[7:0], w_frac_sum[22:0]};
    w_rnd_ovrf = 1'b0;
    w_rnd_udrf = 1'b0;
    if (w_exp_f >= 10'sd255) begin
      w_rnd_z    = {w_sign, 31'h7F80_0000};
      w_rnd_ovrf = 1'b1;
    end else if (w_exp_f <= 10'sd0) begin
      w_rnd_z    = {w_sign, 31'd0};
      w_rnd_udrf = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_rmode_nxt = r_rmode;
    w_rem_nxt   = r_rem;
    w_quo_nxt   = r_quo;
    w_cnt_nxt   = r_cnt;
    w_z_nxt     = r_z;
    w_ovrf_nxt  = r_ovrf;
    w_udrf_nxt  = r_udrf;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_x_nxt     = fp_X;
          w_y_nxt     = fp_Y;
          w_rmode_nxt = r_mode;
          w_busy_nxt  = 1'b1;
          if (w_in_special) begin
            w_state_nxt = StSpecial;
          end else begin
            w_state_nxt = StDiv;
            w_cnt_nxt   = '0;
            w_quo_nxt   = '0;
            w_rem_nxt   = {2'b01, fp_X[22:0]};
          end
        end
      end
      StSpecial: begin
        w_z_nxt     = w_sp_z;
        w_ovrf_nxt  = w_sp_ovrf;
        w_udrf_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        w_state_nxt = StIdle;
      end
      StDiv: begin
        w_rem_nxt = w_rem_sub << 1;
        w_quo_nxt = {r_quo[QBITS-2:0], w_ge};
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CntW'(QBITS - 1)) begin
          w_state_nxt = StRound;
        end
      end
      StRound: begin
        w_z_nxt     = w_rnd_z;
        w_ovrf_nxt  = w_rnd_ovrf;
        w_udrf_nxt  = w_rnd_udrf;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_x     <= '0;
      r_y     <= '0;
      r_rmode <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
      r_z     <= '0;
      r_ovrf  <= 1'b0;
      r_udrf  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_rmode <= w_rmode_nxt;
      r_rem   <= w_rem_nxt;
      r_quo   <= w_quo_nxt;
      r_cnt   <= w_cnt_nxt;
      r_z     <= w_z_nxt;
      r_ovrf  <= w_ovrf_nxt;
      r_udrf  <= w_udrf_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign fp_Z = r_z;
  assign ovrf = r_ovrf;
  assign udrf = r_udrf;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: rounding modes, special cases, range limits,
// handshake and mid-operation reset, all against hand-computed results.
module tb_fp_div_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] fp_X;
  logic [31:0] fp_Y;
  logic [2:0]  r_mode;
  logic [31:0] fp_Z;
  logic        ovrf;
  logic        udrf;
  logic        busy;
  logic        done;

  int n_checks;
  int n_fail;

  fp_div_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .fp_X   (fp_X),
    .fp_Y   (fp_Y),
    .r_mode (r_mode),
    .fp_Z   (fp_Z),
    .ovrf   (ovrf),
    .udrf   (udrf),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at the negedge after the accepting edge; returns edges until done and busy samples.
  task automatic wait_done(output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    while (!done && lat < 100) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [2:0] mode, input logic [31:0] exp_z,
                         input logic exp_ov, input logic exp_ud, input int exp_lat);
    int lat;
    int nb;
    @(negedge clk);
    fp_X   = x;
    fp_Y   = y;
    r_mode = mode;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, nb);
    check_eq({tag, " z"}, fp_Z, exp_z);
    check_eq({tag, " ovrf"}, {31'd0, ovrf}, {31'd0, exp_ov});
    check_eq({tag, " udrf"}, {31'd0, udrf}, {31'd0, exp_ud});
    check_eq({tag, " latency"}, lat, exp_lat);
    check_eq({tag, " busy_cycles"}, nb, exp_lat);
  endtask

  initial begin
    int lat;
    int nb;
    int ndone;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    fp_X     = '0;
    fp_Y     = '0;
    r_mode   = '0;
    repeat (2) @(negedge clk);
    check_eq("reset z", fp_Z, 32'h0);
    check_eq("reset flags_busy_done", {28'd0, ovrf, udrf, busy, done}, 32'h0);
    rst = 1'b0;

    run_vec("6/2 rne", 32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 1'b0, 1'b0, 29);
    check_eq("6/2 done_in_cycle", {31'd0, done}, 32'd1);
    check_eq("6/2 busy_in_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_eq("6/2 done_one_cycle", {31'd0, done}, 32'd0);

    run_vec("1/3 rne", 32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 1'b0, 1'b0, 29);
    run_vec("1/3 rtz", 32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 1'b0, 1'b0, 29);
    run_vec("1/3 rdn", 32'h3F800000, 32'h40400000, 3'b010, 32'h3EAAAAAA, 1'b0, 1'b0, 29);
    run_vec("1/3 rup", 32'h3F800000, 32'h40400000, 3'b011, 32'h3EAAAAAB, 1'b0, 1'b0, 29);
    run_vec("1/3 rmm", 32'h3F800000, 32'h40400000, 3'b100, 32'h3EAAAAAB, 1'b0, 1'b0, 29);
    run_vec("-1/3 rdn", 32'hBF800000, 32'h40400000, 3'b010, 32'hBEAAAAAB, 1'b0, 1'b0, 29);
    run_vec("-1/3 rup", 32'hBF800000, 32'h40400000, 3'b011, 32'hBEAAAAAA, 1'b0, 1'b0, 29);

    run_vec("1/0", 32'h3F800000, 32'h00000000, 3'b000, 32'h7F800000, 1'b1, 1'b0, 1);
    run_vec("0/-0", 32'h00000000, 32'h80000000, 3'b000, 32'h7FC00000, 1'b0, 1'b0, 1);
    run_vec("-0/1", 32'h80000000, 32'h3F800000, 3'b000, 32'h80000000, 1'b0, 1'b0, 1);
    run_vec("inf/inf", 32'h7F800000, 32'h7F800000, 3'b000, 32'h7FC00000, 1'b0, 1'b0, 1);
    run_vec("sub/1", 32'h00400000, 32'h3F800000, 3'b000, 32'h00000000, 1'b0, 1'b0, 1);

    run_vec("ovf", 32'h7F000000, 32'h00800000, 3'b000, 32'h7F800000, 1'b1, 1'b0, 29);
    run_vec("udf", 32'h00800000, 32'h40000000, 3'b000, 32'h00000000, 1'b0, 1'b1, 29);
    run_vec("after_udf", 32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 1'b0, 1'b0, 29);

    // start held high; operands change after acceptance and must not be picked up mid-op
    @(negedge clk);
    fp_X   = 32'h40C00000;
    fp_Y   = 32'h40000000;
    r_mode = 3'b000;
    start  = 1'b1;
    @(negedge clk);
    fp_X = 32'h3F800000;
    fp_Y = 32'h40400000;
    wait_done(lat, nb);
    check_eq("hold z", fp_Z, 32'h40400000);
    check_eq("hold latency", lat, 29);
    check_eq("hold busy_cycles", nb, 29);
    @(negedge clk);
    check_eq("hold restart_busy", {31'd0, busy}, 32'd1);
    check_eq("hold restart_done", {31'd0, done}, 32'd0);
    start = 1'b0;
    wait_done(lat, nb);
    check_eq("hold second z", fp_Z, 32'h3EAAAAAB);
    check_eq("hold second latency", lat, 29);

    // reset 10 cycles into DIV aborts with no done pulse
    @(negedge clk);
    fp_X  = 32'h40C00000;
    fp_Y  = 32'h40000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("abort busy", {31'd0, busy}, 32'd0);
    check_eq("abort z", fp_Z, 32'h0);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_eq("abort no_done", ndone, 0);
    run_vec("post_abort", 32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 1'b0, 1'b0, 29);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
